// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the fp_mult_sched multiplier scheduler.
package fp_sched_pkg;

    localparam int unsigned FP_W     = 32;
    localparam int unsigned STATUS_W = 8;
    // Widest requester ID (NUM_REQ <= 8); narrower builds use the low bits.
    localparam int unsigned ID_MAX_W = 3;

    // Rounding modes used to configure the shared multiplier instance.
    typedef enum logic [2:0] {
        RoundNearestEven   = 3'd0,
        RoundToZero        = 3'd1,
        RoundUp            = 3'd2,
        RoundDown          = 3'd3,
        RoundNearestMaxMag = 3'd4
    } round_values;

    // One result FIFO entry.
    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [FP_W-1:0]     z;
        logic [STATUS_W-1:0] status;
    } fp_result_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating pointer.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic               gnt_vld_o
);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] idx;

    // First valid request at or after the pointer wins, when enabled.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        idx       = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = ID_W'((int'(ptr_q) + k) % int'(NUM_REQ));
            if (en_i && !gnt_vld_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
                gnt_vld_o  = 1'b1;
            end
        end
        ptr_d = gnt_vld_o ? ID_W'((int'(gnt_idx_o) + 1) % int'(NUM_REQ)) : ptr_q;
    end

    // Pointer moves past the winner on every grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fp_mult_sched.sv
// Shares one pipelined multiplier among NUM_REQ requesters with in-order,
// credit-protected result return. Optional statistics counters are built
// when FP_MULT_SCHED_STATS_EN is defined.
module fp_mult_sched
    import fp_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned MULT_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    output logic [FP_W-1:0]         mult_a,
    output logic [FP_W-1:0]         mult_b,
    input  logic [FP_W-1:0]         mult_z,
    input  logic [STATUS_W-1:0]     mult_status,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [FP_W-1:0]         resp_z,
    output logic [STATUS_W-1:0]     resp_status,
`ifdef FP_MULT_SCHED_STATS_EN
    output logic [31:0]             issue_cnt,
    output logic [31:0]             stall_cnt,
`endif
    output logic                    busy
);

    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             credit_ok;
    logic             issue;
    logic [ID_W-1:0]  gnt_idx;

    logic [FP_W-1:0]  op_a [NUM_REQ];
    logic [FP_W-1:0]  op_b [NUM_REQ];
    logic [FP_W-1:0]  mult_a_q, mult_b_q;

    logic [MULT_LAT:0] tag_vld_q;
    logic [ID_W-1:0]   tag_id_q [MULT_LAT+1];

    fp_result_t       mem_q [FIFO_DEPTH];
    fp_result_t       head;
    fp_result_t       push_entry;
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [OCC_W-1:0] cnt_q;
    logic             push, pop;
    logic             unused_head_id;

    for (genvar g = 0; g < int'(NUM_REQ); g++) begin : g_ops
        assign op_a[g] = req_a[FP_W*g +: FP_W];
        assign op_b[g] = req_b[FP_W*g +: FP_W];
    end

    // Reset also masks grants so req_ready is low while rst is held.
    assign credit_ok = occ_q < OCC_W'(FIFO_DEPTH);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req_valid),
        .en_i      (credit_ok && !rst),
        .gnt_o     (req_ready),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (issue)
    );

    // Operand register: loads on issue, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            mult_a_q <= '0;
            mult_b_q <= '0;
        end else if (issue) begin
            mult_a_q <= op_a[gnt_idx];
            mult_b_q <= op_b[gnt_idx];
        end
    end

    assign mult_a = mult_a_q;
    assign mult_b = mult_b_q;

    // Tag valid shift register; stage MULT_LAT lines up with mult_z.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_vld_q <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[MULT_LAT-1:0], issue};
        end
    end

    // Tag IDs ride alongside the valid bits; no reset needed.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= gnt_idx;
        for (int k = 1; k <= int'(MULT_LAT); k++) begin
            tag_id_q[k] <= tag_id_q[k-1];
        end
    end

    assign push = tag_vld_q[MULT_LAT];
    assign pop  = resp_valid && resp_ready;

    always_comb begin
        push_entry        = '0;
        push_entry.id     = ID_MAX_W'(tag_id_q[MULT_LAT]);
        push_entry.z      = mult_z;
        push_entry.status = mult_status;
    end

    // FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= push_entry;
        end
    end

    // FIFO pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Credit: a pop returns its credit one cycle later via the register.
    assign occ_d = occ_q + OCC_W'(issue) - OCC_W'(pop);

    // Occupancy register (in flight plus queued).
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign head           = mem_q[rd_q];
    assign unused_head_id = ^head.id;
    assign resp_valid     = cnt_q != '0;
    assign resp_id        = resp_valid ? head.id[ID_W-1:0] : '0;
    assign resp_z         = resp_valid ? head.z : '0;
    assign resp_status    = resp_valid ? head.status : '0;
    assign busy           = occ_q != '0;

`ifdef FP_MULT_SCHED_STATS_EN
    logic [31:0] issue_cnt_q, stall_cnt_q;
    logic        stall;

    assign stall = (|req_valid) && !issue && !credit_ok;

    // Saturating issue and credit-stall counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue && (issue_cnt_q != '1)) issue_cnt_q <= issue_cnt_q + 1'b1;
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_fp_mult_sched.sv
// Scoreboard bench for fp_mult_sched with a behavioural pipelined multiplier.
module tb_fp_mult_sched;
    import fp_sched_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int MULT_LAT   = 2;
    localparam int FIFO_DEPTH = 4;
    localparam int ID_W       = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*32-1:0]   req_a, req_b;
    logic [31:0]             mult_a, mult_b, mult_z;
    logic [7:0]              mult_status;
    logic                    resp_valid, resp_ready;
    logic [ID_W-1:0]         resp_id;
    logic [31:0]             resp_z;
    logic [7:0]              resp_status;
    logic                    busy;
`ifdef FP_MULT_SCHED_STATS_EN
    logic [31:0]             issue_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    fp_mult_sched #(
        .NUM_REQ    (NUM_REQ),
        .MULT_LAT   (MULT_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .mult_a      (mult_a),
        .mult_b      (mult_b),
        .mult_z      (mult_z),
        .mult_status (mult_status),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_z      (resp_z),
        .resp_status (resp_status),
`ifdef FP_MULT_SCHED_STATS_EN
        .issue_cnt   (issue_cnt),
        .stall_cnt   (stall_cnt),
`endif
        .busy        (busy)
    );

    // Truncating normal-number multiply; status stub = b[31:24] + 1.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        if (p[47]) begin
            e = int'(a[30:23]) + int'(b[30:23]) - 126;
            m = p[46:24];
        end else begin
            e = int'(a[30:23]) + int'(b[30:23]) - 127;
            m = p[45:23];
        end
        return {a[31] ^ b[31], e[7:0], m};
    endfunction

    logic [31:0] pz [MULT_LAT];
    logic [7:0]  ps [MULT_LAT];
    always @(posedge clk) begin
        pz[0] <= fmul(mult_a, mult_b);
        ps[0] <= mult_b[31:24] + 8'd1;
        for (int k = 1; k < MULT_LAT; k++) begin
            pz[k] <= pz[k-1];
            ps[k] <= ps[k-1];
        end
    end
    assign mult_z      = pz[MULT_LAT-1];
    assign mult_status = ps[MULT_LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] z;
        logic [7:0]  st;
    } exp_t;

    exp_t        sb [$];
    int          hs_id [$];
    int          hs_cyc [$];
    int          pop_cyc [$];
    int          hs_count = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_z [NUM_REQ];
    logic [7:0]  exp_st [NUM_REQ];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: handshakes push expectations, responses pop and compare.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        sb.push_back('{i, exp_z[i], exp_st[i]});
                        hs_id.push_back(i);
                        hs_cyc.push_back(cyc);
                        hs_count++;
                    end
                end
                if (resp_valid && resp_ready) begin
                    pop_cyc.push_back(cyc);
                    if (sb.size() == 0) begin
                        check("resp_unexpected", 32'(resp_valid), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_id", 32'(resp_id), 32'(e.id));
                        check("resp_z", resp_z, e.z);
                        check("resp_status", 32'(resp_status), 32'(e.st));
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        int n = 0;
        while (hs_count < target && n < budget) begin
            tick();
            n++;
        end
        if (hs_count < target) check(name, 32'(hs_count), 32'(target));
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] z, input logic [7:0] st);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        exp_z[id]  = z;
        exp_st[id] = st;
    endtask

    task automatic send(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] z, input logic [7:0] st);
        set_op(id, a, b, z, st);
        req_valid[id] = 1'b1;
        wait_hs(hs_count + 1, 20, "send_timeout");
        req_valid[id] = 1'b0;
    endtask

    // 2.0 times {2.0, 3.0, 0.5, 1.5}.
    task automatic set_all();
        set_op(0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 8'h41);
        set_op(1, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 8'h41);
        set_op(2, 32'h4000_0000, 32'h3F00_0000, 32'h3F80_0000, 8'h40);
        set_op(3, 32'h4000_0000, 32'h3FC0_0000, 32'h4040_0000, 8'h40);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((busy || sb.size() != 0) && n < 60) begin
            tick();
            n++;
        end
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic clear_logs();
        hs_id.delete();
        hs_cyc.delete();
        pop_cyc.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        int n;
        int seen;
        int base;
        rst        = 1'b1;
        req_valid  = '1;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            exp_z[i]  = '0;
            exp_st[i] = '0;
        end
        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        rst       = 1'b0;
        check("rst_mult_a", mult_a, 32'd0);
        check("rst_mult_b", mult_b, 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_z", resp_z, 32'd0);
        check("rst_resp_status", 32'(resp_status), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();

        // Single op: 1.0 * 2.0 from requester 2, four-cycle response latency.
        clear_logs();
        send(2, 32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 8'h41);
        t = hs_cyc[0];
        check("single_mult_a", mult_a, 32'h3F80_0000);
        check("single_mult_b", mult_b, 32'h4000_0000);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid && n < 20);
        check("single_latency", 32'(cyc - t), 32'(MULT_LAT + 2));
        drain("single");

        // Ordering: (1, 3.0*2.0) then (3, 1.0*1.0).
        send(1, 32'h4040_0000, 32'h4000_0000, 32'h40C0_0000, 8'h41);
        send(3, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 8'h40);
        drain("order");

        // Fairness: all valid, pointer at 0; fifth grant waits one cycle for credit.
        clear_logs();
        set_all();
        base = hs_count;
        req_valid = '1;
        wait_hs(base + 6, 30, "fair_timeout");
        req_valid = '0;
        for (int k = 0; k < 6; k++) begin
            if (k < hs_id.size()) check("fair_order", 32'(hs_id[k]), 32'(k % NUM_REQ));
        end
        if (hs_cyc.size() >= 5) check("fair_credit_gap", 32'(hs_cyc[4] - hs_cyc[3]), 32'd2);
        drain("fair");

        // Reset mid-operation: three issues then reset before any response.
        base = hs_count;
        req_valid = '1;
        wait_hs(base + 3, 20, "rstmid_timeout");
        req_valid = '0;
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_mult_a", mult_a, 32'd0);
        check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("rstmid_no_resp", 32'(seen), 32'd0);
        tick();

        // Backpressure: four issues, then no grants while responses are held.
        clear_logs();
        resp_ready = 1'b0;
        base = hs_count;
        req_valid = '1;
        wait_hs(base + 4, 20, "bp_timeout");
        if (hs_id.size() > 0) check("rstmid_next_grant", 32'(hs_id[0]), 32'd0);
        repeat (10) begin
            @(negedge clk);
            check("bp_ready_zero", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        check("bp_hs_count", 32'(hs_count - base), 32'd4);
`ifdef FP_MULT_SCHED_STATS_EN
        check("stats_issue_cnt", issue_cnt, 32'd4);
        check("stats_stall_cnt", stall_cnt, 32'd10);
`endif
        resp_ready = 1'b1;
        wait_hs(base + 8, 30, "bp_release_timeout");
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            if (4 + k < hs_cyc.size() && k < pop_cyc.size())
                check("bp_issue_after_pop", 32'(hs_cyc[4+k] - pop_cyc[k]), 32'd1);
        end
        drain("bp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
